// File: rtl/buzzer_round_ctrl.sv
// Three-player buzzer round controller: arm, first-press capture with
// A > B > C priority, verdict scoring with saturation, and a timed score display.
module buzzer_round_ctrl #(
    parameter int MAX_SCORE     = 15,
    parameter int ANSWER_CYCLES = 1000,
    parameter int SHOW_CYCLES   = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       buzz_a,
    input  logic       buzz_b,
    input  logic       buzz_c,
    input  logic       arm,
    input  logic       judge_ok,
    input  logic       judge_bad,
    input  logic       clear_scores,
    output logic [3:0] SA,
    output logic [3:0] SB,
    output logic [3:0] SC,
    output logic       score_A,
    output logic       score_B,
    output logic       score_C,
    output logic [2:0] winner,
    output logic       armed,
    output logic       timeout
);

    localparam int AW = (ANSWER_CYCLES > 1) ? $clog2(ANSWER_CYCLES) : 1;
    localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [AW-1:0] A_LOAD = AW'(ANSWER_CYCLES - 1);
    localparam logic [SW-1:0] S_LOAD = SW'(SHOW_CYCLES - 1);
    localparam logic [3:0]    MAXV   = 4'(MAX_SCORE);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ANSWER,
        SHOW
    } state_t;

    state_t        r_state;
    logic [2:0]    r_prev;
    logic [AW-1:0] r_atmr;
    logic [SW-1:0] r_stmr;

    logic [2:0] w_buzz;
    logic [2:0] w_press;
    logic [2:0] w_first;
    logic [3:0] w_cur;
    logic [3:0] w_next;
    logic       w_ok;
    logic       w_bad;
    logic       w_verdict;

    assign w_buzz    = {buzz_a, buzz_b, buzz_c};
    assign w_press   = w_buzz & ~r_prev;
    assign w_ok      = judge_ok & ~judge_bad;
    assign w_bad     = judge_bad & ~judge_ok;
    assign w_verdict = judge_ok | judge_bad;

    // Several presses on one edge are legal, so this must be a priority chain.
    always_comb begin
        w_first = 3'b000;
        if (w_press[2])
            w_first = 3'b100;
        else if (w_press[1])
            w_first = 3'b010;
        else if (w_press[0])
            w_first = 3'b001;
    end

    always_comb begin
        w_cur = SC;
        if (winner[2])
            w_cur = SA;
        else if (winner[1])
            w_cur = SB;
        w_next = w_cur;
        if (w_ok)
            w_next = (w_cur >= MAXV) ? MAXV : w_cur + 4'd1;
        else if (w_bad)
            w_next = (w_cur == 4'd0) ? 4'd0 : w_cur - 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_prev  <= 3'b111;
            r_atmr  <= '0;
            r_stmr  <= '0;
            SA      <= 4'd0;
            SB      <= 4'd0;
            SC      <= 4'd0;
            score_A <= 1'b0;
            score_B <= 1'b0;
            score_C <= 1'b0;
            winner  <= 3'b000;
            armed   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            r_prev <= w_buzz;
            if (clear_scores) begin
                r_state <= IDLE;
                SA      <= 4'd0;
                SB      <= 4'd0;
                SC      <= 4'd0;
                score_A <= 1'b0;
                score_B <= 1'b0;
                score_C <= 1'b0;
                winner  <= 3'b000;
                armed   <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (arm) begin
                            r_state <= ARMED;
                            armed   <= 1'b1;
                            timeout <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (|w_press) begin
                            r_state <= ANSWER;
                            winner  <= w_first;
                            r_atmr  <= A_LOAD;
                            armed   <= 1'b0;
                        end
                    end
                    ANSWER: begin
                        r_atmr <= r_atmr - 1'b1;
                        // A verdict on the final timer cycle beats the timeout.
                        if (w_verdict || r_atmr == '0) begin
                            if (!w_verdict)
                                timeout <= 1'b1;
                            if (winner[2])
                                SA <= w_next;
                            if (winner[1])
                                SB <= w_next;
                            if (winner[0])
                                SC <= w_next;
                            {score_A, score_B, score_C} <= winner;
                            r_stmr  <= S_LOAD;
                            r_state <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (r_stmr == '0) begin
                            r_state <= IDLE;
                            winner  <= 3'b000;
                            score_A <= 1'b0;
                            score_B <= 1'b0;
                            score_C <= 1'b0;
                        end else begin
                            r_stmr <= r_stmr - 1'b1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buzzer_round_ctrl.sv
// Randomised round-level bench for buzzer_round_ctrl against a
// transaction model of scores, winner priority, timeout and display length.
module tb_buzzer_round_ctrl;

    localparam int MAXS = 15;
    localparam int ANS  = 6;
    localparam int SHW  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       buzz_a, buzz_b, buzz_c;
    logic       arm, judge_ok, judge_bad, clear_scores;
    logic [3:0] SA, SB, SC;
    logic       score_A, score_B, score_C;
    logic [2:0] winner;
    logic       armed, timeout;

    int n_run  = 0;
    int n_fail = 0;
    int sc[3];

    always #5 clk = ~clk;

    buzzer_round_ctrl #(
        .MAX_SCORE    (MAXS),
        .ANSWER_CYCLES(ANS),
        .SHOW_CYCLES  (SHW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .buzz_a      (buzz_a),
        .buzz_b      (buzz_b),
        .buzz_c      (buzz_c),
        .arm         (arm),
        .judge_ok    (judge_ok),
        .judge_bad   (judge_bad),
        .clear_scores(clear_scores),
        .SA          (SA),
        .SB          (SB),
        .SC          (SC),
        .score_A     (score_A),
        .score_B     (score_B),
        .score_C     (score_C),
        .winner      (winner),
        .armed       (armed),
        .timeout     (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] onehot(input int w);
        return 3'(3'b100 >> w);
    endfunction

    function automatic int prio(input logic [2:0] m);
        if (m[2]) return 0;
        if (m[1]) return 1;
        return 2;
    endfunction

    task automatic check_scores(input string tag);
        check({tag, "_SA"}, SA, sc[0]);
        check({tag, "_SB"}, SB, sc[1]);
        check({tag, "_SC"}, SC, sc[2]);
    endtask

    // vk: 0 ok, 1 bad, 2 both, 3 none; d = ANSWER cycles before the verdict
    task automatic round(input logic [2:0] m, input int pre,
                         input int vk, input int d);
        int w, ent, exp_ent, cnt;
        bit has_v;
        {buzz_a, buzz_b, buzz_c} = 3'b000;
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("armed", armed, 1);
        check("arm_clears_timeout", timeout, 0);
        for (int i = 0; i < pre; i++) begin
            judge_ok  = 1'($urandom_range(0, 1));
            judge_bad = 1'($urandom_range(0, 1));
            arm       = 1'($urandom_range(0, 1));
            step();
            {judge_ok, judge_bad, arm} = 3'b000;
        end
        check("armed_wait", {armed, winner}, 4'b1000);
        check_scores("armed_noise");
        {buzz_a, buzz_b, buzz_c} = m;
        step();
        w = prio(m);
        check("winner", winner, onehot(w));
        check("armed_off", armed, 0);
        {buzz_a, buzz_b, buzz_c} = 3'b111;
        ent = -1;
        for (int i = 0; i < ANS + 2 && ent < 0; i++) begin
            if (i == d) begin
                judge_ok  = (vk == 0 || vk == 2);
                judge_bad = (vk == 1 || vk == 2);
            end
            step();
            {judge_ok, judge_bad} = 2'b00;
            if ({score_A, score_B, score_C} != 3'b000)
                ent = i;
            else
                check("lockout", winner, onehot(w));
        end
        has_v   = (vk != 3) && (d < ANS);
        exp_ent = has_v ? d : ANS - 1;
        check("enter_show", ent, exp_ent);
        if (has_v && vk == 0)
            sc[w] = (sc[w] + 1 > MAXS) ? MAXS : sc[w] + 1;
        if (has_v && vk == 1)
            sc[w] = (sc[w] == 0) ? 0 : sc[w] - 1;
        check("timeout", timeout, !has_v);
        check_scores("verdict");
        check("show_sel", {score_A, score_B, score_C}, onehot(w));
        cnt = 1;
        for (int i = 0; i < SHW + 3; i++) begin
            judge_ok  = 1'($urandom_range(0, 1));
            judge_bad = 1'($urandom_range(0, 1));
            step();
            {judge_ok, judge_bad} = 2'b00;
            if ({score_A, score_B, score_C} == 3'b000)
                break;
            cnt++;
        end
        check("show_len", cnt, SHW);
        check("idle_winner", winner, 0);
        check_scores("show_noise");
        judge_ok = 1'b1;
        step();
        judge_ok  = 1'b0;
        judge_bad = 1'b1;
        step();
        judge_bad = 1'b0;
        check_scores("idle_noise");
        check("idle_armed", armed, 0);
    endtask

    initial begin
        sc = '{0, 0, 0};
        rst = 1'b1;
        {buzz_a, buzz_b, buzz_c} = 3'b100;
        {arm, judge_ok, judge_bad, clear_scores} = 4'b0000;
        #2;
        check("reset_out", {SA, SB, SC, score_A, score_B, score_C,
                            winner, armed, timeout}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("held_no_win", {armed, winner}, 4'b1000);
        end
        buzz_a = 1'b0;
        step();
        buzz_a = 1'b1;
        step();
        check("repress_win", winner, 3'b100);
        judge_ok = 1'b1;
        step();
        judge_ok = 1'b0;
        sc[0] = 1;
        check_scores("first_ok");
        repeat (SHW) step();
        check("first_idle", {winner, score_A, score_B, score_C}, 0);

        round(3'b011, 1, 0, 1);
        for (int i = 0; i < 16; i++)
            round(3'b100, $urandom_range(0, 2), 0, $urandom_range(0, ANS - 1));
        check("sat_hi", SA, 15);
        round(3'b001, 0, 1, 0);
        check("sat_lo", SC, 0);
        for (int i = 0; i < 4; i++)
            round(3'b010, 0, 0, 0);
        round(3'b010, 0, 1, 2);
        check("b_dec", SB, 4);
        round(3'b100, 0, 3, 0);
        round(3'b110, 1, 2, 3);
        round(3'b001, 0, 0, ANS - 1);

        {buzz_a, buzz_b, buzz_c} = 3'b000;
        arm = 1'b1;
        step();
        arm = 1'b0;
        buzz_c = 1'b1;
        step();
        check("clr_win", winner, 3'b001);
        step();
        clear_scores = 1'b1;
        judge_ok     = 1'b1;
        step();
        {clear_scores, judge_ok} = 2'b00;
        sc = '{0, 0, 0};
        check_scores("clear");
        check("clear_out", {winner, score_A, score_B, score_C, armed}, 0);
        step();
        check("clear_idle", {winner, score_A, score_B, score_C}, 0);

        for (int i = 0; i < 30; i++)
            round(3'($urandom_range(1, 7)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, ANS + 1));

        {buzz_a, buzz_b, buzz_c} = 3'b000;
        arm = 1'b1;
        step();
        arm = 1'b0;
        buzz_a = 1'b1;
        step();
        judge_ok = 1'b1;
        step();
        judge_ok = 1'b0;
        step();
        check("pre_rst_sel", score_A, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {SA, SB, SC, score_A, score_B, score_C,
                            winner, armed, timeout}, 0);
        sc = '{0, 0, 0};
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        round(3'b101, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/buzzer_round_ctrl.md
Name: buzzer_round_ctrl

Overview:
- Round controller for the three-player buzzer scoring system.
- Arms a question round and detects the first buzzer press. Simultaneous presses are resolved by fixed priority A > B > C.
- Waits for the quizmaster's verdict, updates the 4-bit per-player scores, then drives the one-hot score-select strobes into the score-to-digits display stage.
- Sits between the debounced buzzer/judge inputs and the display datapath.

Parameters:
- MAX_SCORE, 15: saturation ceiling for each score; must be ≤ 15.
- ANSWER_CYCLES, 1000: cycles allowed for a verdict after a buzz before timeout; must be ≥ 1.
- SHOW_CYCLES, 500: cycles the winner's score-select strobe is held in SHOW; must be ≥ 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- buzz_a, buzz_b, buzz_c  in  1 each  debounced, synchronous buzzer levels.
- arm  in  1  single-cycle pulse that opens a round.
- judge_ok  in  1  single-cycle pulse, answer correct.
- judge_bad  in  1  single-cycle pulse, answer wrong.
- clear_scores  in  1  single-cycle pulse, zero all scores and abort the round.
- SA, SB, SC  out  4 each  current scores.
- score_A, score_B, score_C  out  1 each  one-hot display select, high only in SHOW.
- winner  out  3  one-hot {A,B,C} of the player holding the round; 000 when none.
- armed  out  1  high in ARMED (buzzers live).
- timeout  out  1  sticky; set when a round times out, cleared on the next arm.

Behaviour:
- States: IDLE, ARMED, ANSWER, SHOW. All state and outputs are registered.
- Reset (async assert; release synchronous to clk):
  - state = IDLE; SA = SB = SC = 0; score_A/B/C = 0; winner = 000; armed = 0; timeout = 0.
  - Buzzer history registers = 1, so a buzzer held through reset never counts as a press.
- Edge detect: press_x = buzz_x & ~prev_x. prev_x updates every cycle in every state, so a buzzer held while arm fires produces no press.
- IDLE:
  - Buzzers and judge pulses are ignored.
  - arm → ARMED next edge; timeout cleared.
- ARMED:
  - armed = 1.
  - On the first edge where any press_x = 1: winner = highest-priority pressing player (A > B > C), answer timer loaded with ANSWER_CYCLES-1, state → ANSWER.
  - Zero-cycle latency: winner is valid right after the sampling edge.
  - Presses after the winning edge are ignored (lockout).
  - arm while ARMED: no effect.
- ANSWER:
  - judge_ok alone: winner's score + 1, saturating at MAX_SCORE → SHOW.
  - judge_bad alone: winner's score − 1, saturating at 0 → SHOW.
  - judge_ok and judge_bad in the same cycle: no score change → SHOW.
  - Timer reaching 0 with no verdict: no score change; timeout = 1 → SHOW.
  - A verdict in the same cycle the timer reaches 0 takes precedence; timeout stays 0.
  - Timer decrements once per cycle in ANSWER.
- SHOW:
  - The score_X matching winner is held at 1; the others are 0. The updated score is already visible on SA/SB/SC.
  - Counter runs SHOW_CYCLES cycles, then → IDLE; winner = 000 and score_X = 0 on that edge.
- clear_scores, any state: next edge SA = SB = SC = 0; winner = 000; score_X = 0; state = IDLE. It overrides a same-cycle verdict or arm.
- Score arithmetic is 4-bit unsigned. Only the winner's score ever changes; other scores are untouched.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit.

Test Plan:
- Reset with buzz_a held high, then arm, then hold buzz_a → no win; release and re-press buzz_a → winner = 100 one cycle after the press edge.
- arm; buzz_b and buzz_c rise in the same cycle → winner = 010; a later buzz_a press is ignored; judge_ok → SB = 1; score_B high for exactly SHOW_CYCLES cycles, then IDLE with winner = 000.
- Saturation:
  - SA = 15, A wins, judge_ok → SA stays 15.
  - SC = 0, C wins, judge_bad → SC stays 0.
  - SB = 5, B wins, judge_bad → SB = 4.
- A wins; no verdict for ANSWER_CYCLES cycles → timeout = 1, SA unchanged, enters SHOW; next arm clears timeout.
- judge_ok and judge_bad asserted together in ANSWER → score unchanged, enters SHOW, timeout = 0; verdict pulses in IDLE/ARMED/SHOW change nothing.
- Asynchronous reset mid-SHOW and clear_scores mid-ANSWER:
  - reset → all outputs 0 immediately, without a clock edge;
  - clear_scores → next edge scores 0 and state IDLE; a same-cycle judge_ok is ignored.
